falling_note_lanes: RTL and testbench

Multi-lane, parametrised successor to the single-box note sprite. It holds up to SLOTS falling notes per lane in on-chip slot registers and scrolls them down once per frame. It judges key presses against a hit line and renders the whole note field into the pixel stream with a fixed two-cycle latency. It sits between the game controller (spawn/key inputs, hit/miss outputs) and the video mux (RGB outputs).

---
 rtl/falling_note_lanes.sv | 195 +++++++++++++++++++
 tb/tb_falling_note_lanes.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falling_note_lanes.sv
// Multi-lane falling-note field: per-lane slot registers scrolled once per frame, key judging
// against a hit line, and a fixed two-cycle render pipeline into the pixel stream.
module falling_note_lanes #(
   parameter int          LANES       = 4,
   parameter int          SLOTS       = 8,
   parameter int          NOTE_WIDTH  = 50,
   parameter int          NOTE_HEIGHT = 50,
   parameter int          LANE_X0     = 100,
   parameter int          LANE_PITCH  = 60,
   parameter int          SPEED       = 4,
   parameter int          SCREEN_H    = 720,
   parameter int          HIT_Y       = 600,
   parameter int          HIT_TOL     = 20,
   parameter logic [23:0] BG_COLOR    = 24'hFFFFFF,
   parameter logic [23:0] LINE_COLOR  = 24'h808080,
   localparam int         LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [10:0]      hcount_in,
   input  logic [9:0]       vcount_in,
   input  logic             new_frame_in,
   input  logic             spawn_valid_in,
   input  logic [LW-1:0]    spawn_lane_in,
   input  logic [23:0]      spawn_color_in,
   output logic             spawn_ready_out,
   input  logic [LANES-1:0] key_in,
   output logic [LANES-1:0] hit_out,
   output logic [LANES-1:0] miss_out,
   output logic [7:0]       red_out,
   output logic [7:0]       green_out,
   output logic [7:0]       blue_out
);

   logic [SLOTS-1:0] valid_q  [LANES];
   logic [SLOTS-1:0] valid_d  [LANES];
   logic [9:0]       y_q      [LANES][SLOTS];
   logic [9:0]       y_d      [LANES][SLOTS];
   logic [23:0]      color_q  [LANES][SLOTS];
   logic [23:0]      color_d  [LANES][SLOTS];
   logic [10:0]      y_next   [LANES][SLOTS];

   logic [SLOTS-1:0] hit_sel  [LANES];
   logic [SLOTS-1:0] free_sel [LANES];
   logic [LANES-1:0] lane_free;
   logic             sel_free;
   logic             spawn_fire;

   logic [LANES-1:0] key_q;
   logic [LANES-1:0] key_rise;
   logic [LANES-1:0] hit_q;
   logic [LANES-1:0] hit_d;
   logic [LANES-1:0] miss_q;
   logic [LANES-1:0] miss_d;

   logic [LANES-1:0] x_in;
   logic [SLOTS-1:0] inside_d [LANES];
   logic [SLOTS-1:0] inside_q [LANES];
   logic             on_line_d;
   logic             on_line_q;
   logic [23:0]      pix_d;
   logic [23:0]      pix_q;

   // Note centre within HIT_TOL of the hit line, kept unsigned by moving HIT_TOL across.
   function automatic logic in_window(input logic [9:0] y);
      logic [11:0] ctr;
      ctr = {2'b00, y} + 12'(NOTE_HEIGHT / 2);
      return ((ctr + 12'(HIT_TOL)) >= 12'(HIT_Y)) && (ctr <= 12'(HIT_Y + HIT_TOL));
   endfunction

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         hit_sel[l]  = '0;
         free_sel[l] = '0;
         for (int s = SLOTS - 1; s >= 0; s--) begin
            if (valid_q[l][s] && in_window(y_q[l][s])) begin
               hit_sel[l]    = '0;
               hit_sel[l][s] = 1'b1;
            end
            if (!valid_q[l][s]) begin
               free_sel[l]    = '0;
               free_sel[l][s] = 1'b1;
            end
         end
         lane_free[l] = ~&valid_q[l];
      end
   end

   // Lane numbers at or above LANES never match, so ready stays low for them.
   always_comb begin
      sel_free = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         if (spawn_lane_in == LW'(l)) sel_free = lane_free[l];
      end
   end

   assign spawn_ready_out = !new_frame_in && sel_free;
   assign spawn_fire      = spawn_valid_in && spawn_ready_out;
   assign key_rise        = key_in & ~key_q;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         for (int s = 0; s < SLOTS; s++) begin
            y_next[l][s] = {1'b0, y_q[l][s]} + 11'(SPEED);
         end
      end
   end

   // A hit outranks the frame scroll on the same slot; spawns only target free slots.
   always_comb begin
      valid_d = valid_q;
      y_d     = y_q;
      color_d = color_q;
      hit_d   = '0;
      miss_d  = '0;
      for (int l = 0; l < LANES; l++) begin
         hit_d[l] = key_rise[l] && (|hit_sel[l]);
         for (int s = 0; s < SLOTS; s++) begin
            if (hit_d[l] && hit_sel[l][s]) begin
               valid_d[l][s] = 1'b0;
            end else if (new_frame_in && valid_q[l][s]) begin
               if (y_next[l][s] >= 11'(SCREEN_H)) begin
                  valid_d[l][s] = 1'b0;
                  miss_d[l]     = 1'b1;
               end else begin
                  y_d[l][s] = y_next[l][s][9:0];
               end
            end
            if (spawn_fire && (spawn_lane_in == LW'(l)) && free_sel[l][s]) begin
               valid_d[l][s] = 1'b1;
               y_d[l][s]     = '0;
               color_d[l][s] = spawn_color_in;
            end
         end
      end
   end

   always_comb begin
      on_line_d = (vcount_in == 10'(HIT_Y));
      for (int l = 0; l < LANES; l++) begin
         x_in[l] = ({1'b0, hcount_in} >= 12'(LANE_X0 + l * LANE_PITCH)) &&
                   ({1'b0, hcount_in} <  12'(LANE_X0 + l * LANE_PITCH + NOTE_WIDTH));
         for (int s = 0; s < SLOTS; s++) begin
            inside_d[l][s] = valid_q[l][s] && x_in[l] &&
                             ({1'b0, vcount_in} >= {1'b0, y_q[l][s]}) &&
                             ({1'b0, vcount_in} <  ({1'b0, y_q[l][s]} + 11'(NOTE_HEIGHT)));
         end
      end
   end

   // Scanning from the highest index down leaves the lowest lane/slot as the winner.
   always_comb begin
      pix_d = on_line_q ? LINE_COLOR : BG_COLOR;
      for (int l = LANES - 1; l >= 0; l--) begin
         for (int s = SLOTS - 1; s >= 0; s--) begin
            if (inside_q[l][s]) pix_d = color_q[l][s];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int l = 0; l < LANES; l++) begin
            valid_q[l]  <= '0;
            inside_q[l] <= '0;
            for (int s = 0; s < SLOTS; s++) begin
               y_q[l][s]     <= '0;
               color_q[l][s] <= '0;
            end
         end
         key_q     <= '0;
         hit_q     <= '0;
         miss_q    <= '0;
         on_line_q <= 1'b0;
         pix_q     <= BG_COLOR;
      end else begin
         valid_q   <= valid_d;
         y_q       <= y_d;
         color_q   <= color_d;
         key_q     <= key_in;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         inside_q  <= inside_d;
         on_line_q <= on_line_d;
         pix_q     <= pix_d;
      end
   end

   assign hit_out   = hit_q;
   assign miss_out  = miss_q;
   assign red_out   = pix_q[23:16];
   assign green_out = pix_q[15:8];
   assign blue_out  = pix_q[7:0];

endmodule

// File: tb/tb_falling_note_lanes.sv
// Scoreboard bench for falling_note_lanes: a note-list reference model queues expected
// ready/hit/miss/RGB values per cycle and a negedge monitor compares them as they fall due.
module tb_falling_note_lanes;
   localparam int          LANES       = 4;
   localparam int          SLOTS       = 8;
   localparam int          NOTE_WIDTH  = 50;
   localparam int          NOTE_HEIGHT = 50;
   localparam int          LANE_X0     = 100;
   localparam int          LANE_PITCH  = 60;
   localparam int          SPEED       = 4;
   localparam int          SCREEN_H    = 720;
   localparam int          HIT_Y       = 600;
   localparam int          HIT_TOL     = 20;
   localparam logic [23:0] BG          = 24'hFFFFFF;
   localparam logic [23:0] LINE        = 24'h808080;

   logic        clk_in   = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [10:0] hcount   = '0;
   logic [9:0]  vcount   = '0;
   logic        nf       = 1'b0;
   logic        sv       = 1'b0;
   logic [1:0]  sl       = '0;
   logic [23:0] sc       = '0;
   logic [3:0]  key      = '0;
   logic        ready;
   logic [3:0]  hit;
   logic [3:0]  miss;
   logic [7:0]  red, green, blue;

   always #5 clk_in = ~clk_in;

   falling_note_lanes dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .hcount_in       (hcount),
      .vcount_in       (vcount),
      .new_frame_in    (nf),
      .spawn_valid_in  (sv),
      .spawn_lane_in   (sl),
      .spawn_color_in  (sc),
      .spawn_ready_out (ready),
      .key_in          (key),
      .hit_out         (hit),
      .miss_out        (miss),
      .red_out         (red),
      .green_out       (green),
      .blue_out        (blue)
   );

   typedef struct { int due; logic [23:0] val; } rgb_t;
   typedef struct { int due; logic [3:0] h; logic [3:0] m; } ev_t;
   typedef struct { int due; logic r; } rdy_t;

   rgb_t q_rgb[$];
   ev_t  q_ev[$];
   rdy_t q_rdy[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int hit_seen[LANES];
   int miss_seen[LANES];

   // Reference note field: y of each slot, -1 for an empty slot.
   int          my[LANES][SLOTS];
   logic [23:0] mc[LANES][SLOTS];
   logic [3:0]  mkey = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [23:0] model_pix(input int h, input int v);
      for (int l = 0; l < LANES; l++) begin
         for (int s = 0; s < SLOTS; s++) begin
            if (my[l][s] >= 0 &&
                h >= LANE_X0 + l * LANE_PITCH && h < LANE_X0 + l * LANE_PITCH + NOTE_WIDTH &&
                v >= my[l][s] && v < my[l][s] + NOTE_HEIGHT)
               return mc[l][s];
         end
      end
      return (v == HIT_Y) ? LINE : BG;
   endfunction

   task automatic model_clear();
      for (int l = 0; l < LANES; l++)
         for (int s = 0; s < SLOTS; s++) begin
            my[l][s] = -1;
            mc[l][s] = '0;
         end
      mkey = '0;
   endtask

   // Called once per cycle after inputs are set: queue expectations, then advance the model.
   task automatic eval();
      int         free_s;
      logic       rdy;
      logic [3:0] eh;
      logic [3:0] em;
      int         d;
      int         ln;
      if (!rst_n_in) begin
         q_rgb.delete();
         q_ev.delete();
         model_clear();
         q_rdy.push_back('{due: cyc, r: !nf});
         for (int k = 0; k < 3; k++) q_rgb.push_back('{due: cyc + k, val: BG});
         for (int k = 0; k < 2; k++) q_ev.push_back('{due: cyc + k, h: 4'b0, m: 4'b0});
         return;
      end
      ln = int'(sl);
      free_s = -1;
      for (int s = SLOTS - 1; s >= 0; s--) if (my[ln][s] < 0) free_s = s;
      rdy = !nf && (ln < LANES) && (free_s >= 0);
      q_rdy.push_back('{due: cyc, r: rdy});
      q_rgb.push_back('{due: cyc + 2, val: model_pix(int'(hcount), int'(vcount))});
      eh = '0;
      em = '0;
      for (int l = 0; l < LANES; l++) begin
         if (key[l] && !mkey[l]) begin
            for (int s = 0; s < SLOTS; s++) begin
               if (my[l][s] >= 0) begin
                  d = my[l][s] + NOTE_HEIGHT / 2 - HIT_Y;
                  if (d < 0) d = -d;
                  if (d <= HIT_TOL) begin
                     my[l][s] = -1;
                     eh[l] = 1'b1;
                     break;
                  end
               end
            end
         end
      end
      mkey = key;
      if (nf) begin
         for (int l = 0; l < LANES; l++)
            for (int s = 0; s < SLOTS; s++)
               if (my[l][s] >= 0) begin
                  my[l][s] += SPEED;
                  if (my[l][s] >= SCREEN_H) begin
                     my[l][s] = -1;
                     em[l] = 1'b1;
                  end
               end
      end
      if (sv && rdy) begin
         my[ln][free_s] = 0;
         mc[ln][free_s] = sc;
      end
      q_ev.push_back('{due: cyc + 1, h: eh, m: em});
   endtask

   task automatic step();
      eval();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic rand_pix();
      hcount = 11'($urandom_range(90, 360));
      vcount = 10'($urandom_range(0, 719));
      if ($urandom_range(0, 15) == 0) vcount = 10'(HIT_Y);
   endtask

   task automatic idle(input int n);
      sv = 1'b0;
      nf = 1'b0;
      repeat (n) begin
         rand_pix();
         step();
      end
   endtask

   task automatic frames(input int n);
      sv = 1'b0;
      repeat (n) begin
         nf = 1'b1;
         rand_pix();
         step();
         nf = 1'b0;
         rand_pix();
         step();
      end
   endtask

   task automatic spawn(input int lane, input logic [23:0] col);
      sv = 1'b1;
      sl = 2'(lane);
      sc = col;
      step();
      sv = 1'b0;
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      key = '0;
      nf  = 1'b0;
      sv  = 1'b0;
      step();
      step();
      rst_n_in = 1'b1;
   endtask

   initial begin : monitor
      rgb_t er;
      ev_t  ee;
      rdy_t ed;
      forever begin
         @(negedge clk_in);
         if (q_rdy.size() > 0 && q_rdy[0].due == cyc) begin
            ed = q_rdy.pop_front();
            check("spawn_ready", 32'(ready), 32'(ed.r));
         end
         if (q_ev.size() > 0 && q_ev[0].due == cyc) begin
            ee = q_ev.pop_front();
            check("hit_out", 32'(hit), 32'(ee.h));
            check("miss_out", 32'(miss), 32'(ee.m));
         end
         if (q_rgb.size() > 0 && q_rgb[0].due == cyc) begin
            er = q_rgb.pop_front();
            check("rgb", 32'({red, green, blue}), 32'(er.val));
         end
         for (int l = 0; l < LANES; l++) begin
            if (hit[l] === 1'b1)  hit_seen[l]++;
            if (miss[l] === 1'b1) miss_seen[l]++;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin : stimulus
      int h0;
      int m0;
      for (int l = 0; l < LANES; l++) begin
         hit_seen[l]  = 0;
         miss_seen[l] = 0;
      end
      model_clear();
      @(posedge clk_in);
      #1;
      // reset state and background pixel
      step();
      step();
      rst_n_in = 1'b1;
      hcount = '0;
      vcount = '0;
      sl = 2'd0;
      repeat (4) step();

      // single red note in lane 1, edge pixels either side of the lane boundary
      spawn(1, 24'hFF0000);
      hcount = 11'd170; vcount = 10'd5; step();
      hcount = 11'd159; vcount = 10'd5; step();
      hcount = 11'd209; vcount = 10'd49; step();
      hcount = 11'd210; vcount = 10'd49; step();
      idle(3);

      // fill lane 0, then a ninth request is refused while lane 2 stays free
      do_reset();
      for (int i = 0; i < SLOTS; i++) spawn(0, 24'($urandom));
      sv = 1'b1; sl = 2'd0; sc = 24'h123456; step();
      sv = 1'b0; sl = 2'd2; step();
      idle(3);

      // note reaches the hit window and is judged by a key rising edge
      do_reset();
      spawn(2, 24'h00FF00);
      frames(144);
      hcount = 11'd230; vcount = 10'd580; step();
      h0 = hit_seen[2];
      key = 4'b0100; step();
      key = 4'b0000;
      hcount = 11'd230; vcount = 10'd586; step();
      idle(3);
      check("hit_l2_count", 32'(hit_seen[2] - h0), 32'd1);

      // unplayed note scrolls off the bottom
      do_reset();
      spawn(3, 24'h0000FF);
      m0 = miss_seen[3];
      frames(180);
      idle(3);
      check("miss_l3_count", 32'(miss_seen[3] - m0), 32'd1);

      // key edge in the same cycle as a frame pulse
      do_reset();
      spawn(1, 24'hABCDEF);
      frames(144);
      h0 = hit_seen[1];
      m0 = miss_seen[1];
      nf = 1'b1; key = 4'b0010; step();
      nf = 1'b0; key = 4'b0000;
      idle(4);
      check("coinc_hit_count", 32'(hit_seen[1] - h0), 32'd1);
      check("coinc_miss_count", 32'(miss_seen[1] - m0), 32'd0);

      // asynchronous reset while notes are on screen
      do_reset();
      spawn(0, 24'h112233);
      spawn(2, 24'h445566);
      frames(10);
      hcount = 11'd110; vcount = 10'd45; step();
      step();
      rst_n_in = 1'b0;
      #1;
      check("async_rst_rgb", 32'({red, green, blue}), 32'(BG));
      step();
      step();
      rst_n_in = 1'b1;
      hcount = 11'd110; vcount = 10'd45; step();
      hcount = 11'd230; vcount = 10'd45; step();
      idle(3);

      // randomized play
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         nf = ($urandom_range(0, 3) == 0);
         sv = ($urandom_range(0, 5) == 0);
         sl = 2'($urandom_range(0, 3));
         sc = 24'($urandom);
         for (int l = 0; l < LANES; l++)
            if ($urandom_range(0, 7) == 0) key[l] = ~key[l];
         rand_pix();
         step();
      end
      key = '0;
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
